// File: rtl/instr_encoder_if.sv
// Handshake bundle between a field producer and the RV32I instruction encoder.
// The master drives field bundles and out_ready; the slave returns encoded words.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op_class;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;

   modport master (
      output in_valid, op_class, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err
   );

   modport slave (
      input  in_valid, op_class, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      output in_ready, out_valid, out_instr, out_err
   );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: S1 captures fields, S2 holds the encoded word.
// Define INSTR_ENC_CHECK_EN to replace out-of-range immediates with a flagged NOP.
module instr_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   instr_encoder_if.slave   bus,
   output logic [CNT_W-1:0] enc_count
);

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_R      = 7'b0110011;
   localparam logic [6:0]  OP_I      = 7'b0010011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_LUI    = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;

   logic             s1_valid_r;
   logic [3:0]       s1_op_r;
   logic [4:0]       s1_rd_r;
   logic [4:0]       s1_rs1_r;
   logic [4:0]       s1_rs2_r;
   logic [2:0]       s1_f3_r;
   logic [6:0]       s1_f7_r;
   logic [31:0]      s1_imm_r;
   logic             s2_valid_r;
   logic [31:0]      s2_instr_r;
   logic             s2_err_r;
   logic [CNT_W-1:0] cnt_r;

   logic             s2_load_s;
   logic             s1_adv_s;
   logic             in_ready_s;
   logic             illegal_s;
   logic [31:0]      raw_instr_s;
   logic             fin_err_s;
   logic [31:0]      fin_instr_s;

   assign s2_load_s  = !s2_valid_r || bus.out_ready;
   assign s1_adv_s   = s1_valid_r && s2_load_s;
   assign in_ready_s = !s1_valid_r || s1_adv_s;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = s2_valid_r;
   assign bus.out_instr = s2_instr_r;
   assign bus.out_err   = s2_err_r;
   assign enc_count     = cnt_r;

   // Format the S1 fields into an RV32I word; illegal classes fall through to NOP.
   always_comb begin
      raw_instr_s = NOP;
      illegal_s   = 1'b0;
      case (s1_op_r)
         4'd0: raw_instr_s = {s1_imm_r[11:0], s1_rs1_r, s1_f3_r, s1_rd_r, OP_LOAD};
         4'd1: raw_instr_s = {s1_imm_r[11:5], s1_rs2_r, s1_rs1_r, s1_f3_r, s1_imm_r[4:0], OP_STORE};
         4'd2: raw_instr_s = {s1_f7_r, s1_rs2_r, s1_rs1_r, s1_f3_r, s1_rd_r, OP_R};
         4'd3: begin
            if ((s1_f3_r == 3'b001) || (s1_f3_r == 3'b101)) begin
               raw_instr_s = {s1_f7_r, s1_imm_r[4:0], s1_rs1_r, s1_f3_r, s1_rd_r, OP_I};
            end else begin
               raw_instr_s = {s1_imm_r[11:0], s1_rs1_r, s1_f3_r, s1_rd_r, OP_I};
            end
         end
         4'd4: raw_instr_s = {s1_imm_r[12], s1_imm_r[10:5], s1_rs2_r, s1_rs1_r, s1_f3_r,
                              s1_imm_r[4:1], s1_imm_r[11], OP_BRANCH};
         4'd5: raw_instr_s = {s1_imm_r[20], s1_imm_r[10:1], s1_imm_r[11], s1_imm_r[19:12],
                              s1_rd_r, OP_JAL};
         4'd6: raw_instr_s = {s1_imm_r[31:12], s1_rd_r, OP_LUI};
         4'd7: raw_instr_s = {s1_imm_r[31:12], s1_rd_r, OP_AUIPC};
         4'd8: raw_instr_s = {s1_imm_r[11:0], s1_rs1_r, 3'b000, s1_rd_r, OP_JALR};
         default: begin
            raw_instr_s = NOP;
            illegal_s   = 1'b1;
         end
      endcase
   end

`ifdef INSTR_ENC_CHECK_EN
   logic range_ok_s;

   // True when every bit from w-1 upward equals the sign bit, i.e. v fits in w signed bits.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if ((i >= w) && (v[i] != v[w-1])) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   // Per-class immediate range check.
   always_comb begin
      range_ok_s = 1'b1;
      case (s1_op_r)
         4'd0, 4'd1, 4'd8: range_ok_s = fits_signed(s1_imm_r, 32'd12);
         4'd3: begin
            if ((s1_f3_r == 3'b001) || (s1_f3_r == 3'b101)) begin
               range_ok_s = (s1_imm_r[31:5] == 27'd0);
            end else begin
               range_ok_s = fits_signed(s1_imm_r, 32'd12);
            end
         end
         4'd4:       range_ok_s = fits_signed(s1_imm_r, 32'd13) && !s1_imm_r[0];
         4'd5:       range_ok_s = fits_signed(s1_imm_r, 32'd21) && !s1_imm_r[0];
         4'd6, 4'd7: range_ok_s = (s1_imm_r[11:0] == 12'd0);
         default:    range_ok_s = 1'b1;
      endcase
   end

   // Substitute a flagged NOP for illegal classes or out-of-range immediates.
   always_comb begin
      if (illegal_s || !range_ok_s) begin
         fin_instr_s = NOP;
         fin_err_s   = 1'b1;
      end else begin
         fin_instr_s = raw_instr_s;
         fin_err_s   = 1'b0;
      end
   end
`else
   // Substitute a flagged NOP for illegal classes; immediates are simply truncated.
   always_comb begin
      if (illegal_s) begin
         fin_instr_s = NOP;
         fin_err_s   = 1'b1;
      end else begin
         fin_instr_s = raw_instr_s;
         fin_err_s   = 1'b0;
      end
   end
`endif

   // S1 field capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_op_r    <= 4'd0;
         s1_rd_r    <= 5'd0;
         s1_rs1_r   <= 5'd0;
         s1_rs2_r   <= 5'd0;
         s1_f3_r    <= 3'd0;
         s1_f7_r    <= 7'd0;
         s1_imm_r   <= 32'd0;
      end else if (in_ready_s) begin
         s1_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            s1_op_r  <= bus.op_class;
            s1_rd_r  <= bus.rd;
            s1_rs1_r <= bus.rs1;
            s1_rs2_r <= bus.rs2;
            s1_f3_r  <= bus.funct3;
            s1_f7_r  <= bus.funct7;
            s1_imm_r <= bus.imm;
         end
      end
   end

   // S2 encoded-word register; holds steady while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_instr_r <= 32'd0;
         s2_err_r   <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_instr_r <= fin_instr_s;
            s2_err_r   <= fin_err_s;
         end
      end
   end

   // Count output handshakes, wrapping naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (s2_valid_r && bus.out_ready) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of single-word vectors plus
// back-to-back, backpressure and mid-flight reset sequences.
module tb_instr_encoder;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   localparam int NV = 16;

   logic        clk;
   logic        rst_n;
   logic [15:0] enc_count;
   int          n_cmp;
   int          n_bad;
   vec_t        tbl [NV];

   instr_encoder_if bus ();

   instr_encoder #(.CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .enc_count (enc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm, input logic [31:0] ei, input logic ee);
      vec_t v;
      v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.imm = imm;
      v.exp_instr = ei; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic put(input vec_t v, input logic vld);
      bus.in_valid = vld;
      bus.op_class = v.op;
      bus.rd       = v.rd;
      bus.rs1      = v.rs1;
      bus.rs2      = v.rs2;
      bus.funct3   = v.f3;
      bus.funct7   = v.f7;
      bus.imm      = v.imm;
   endtask

   initial begin
      int   seq [4];
      vec_t bp [3];
      int   idx;
      int   oidx;

      n_cmp = 0;
      n_bad = 0;
      tbl[0]  = mk(4'd3, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd5,        32'h0050_0093, 1'b0);
      tbl[1]  = mk(4'd2, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'd0,        32'h0020_81B3, 1'b0);
      tbl[2]  = mk(4'd2, 5'd1,  5'd2,  5'd3,  3'd0, 7'h20, 32'd0,        32'h4031_00B3, 1'b0);
      tbl[3]  = mk(4'd1, 5'd0,  5'd1,  5'd2,  3'd2, 7'h00, 32'd8,        32'h0020_A423, 1'b0);
      tbl[4]  = mk(4'd5, 5'd1,  5'd31, 5'd31, 3'd7, 7'h7F, 32'd8,        32'h0080_00EF, 1'b0);
      tbl[5]  = mk(4'd6, 5'd5,  5'd9,  5'd9,  3'd3, 7'h11, 32'h1234_5000, 32'h1234_52B7, 1'b0);
      tbl[6]  = mk(4'd7, 5'd10, 5'd0,  5'd0,  3'd0, 7'h00, 32'hABCD_E000, 32'hABCD_E517, 1'b0);
      tbl[7]  = mk(4'd4, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'd8,        32'h0020_8463, 1'b0);
      tbl[8]  = mk(4'd4, 5'd0,  5'd0,  5'd0,  3'd1, 7'h00, 32'hFFFF_FFFC, 32'hFE00_1EE3, 1'b0);
      tbl[9]  = mk(4'd8, 5'd1,  5'd5,  5'd0,  3'd7, 7'h00, 32'h10,       32'h0102_80E7, 1'b0);
      tbl[10] = mk(4'd3, 5'd2,  5'd3,  5'd0,  3'd1, 7'h00, 32'd4,        32'h0041_9113, 1'b0);
      tbl[11] = mk(4'd3, 5'd2,  5'd3,  5'd0,  3'd5, 7'h20, 32'd2,        32'h4021_D113, 1'b0);
      tbl[12] = mk(4'd0, 5'd4,  5'd2,  5'd0,  3'd2, 7'h00, 32'hFFFF_FFFF, 32'hFFF1_2203, 1'b0);
      tbl[13] = mk(4'd9, 5'd4,  5'd2,  5'd1,  3'd0, 7'h00, 32'd1,        32'h0000_0013, 1'b1);
      tbl[14] = mk(4'hF, 5'd7,  5'd7,  5'd7,  3'd7, 7'h7F, 32'd3,        32'h0000_0013, 1'b1);
`ifdef INSTR_ENC_CHECK_EN
      tbl[15] = mk(4'd3, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd4096,     32'h0000_0013, 1'b1);
`else
      tbl[15] = mk(4'd3, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd4096,     32'h0000_0093, 1'b0);
`endif

      // Reset state.
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      put(tbl[0], 1'b0);
      #12;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      chk("rst_out_err",   {31'd0, bus.out_err}, 32'd0);
      chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Table: one word at a time, check latency and encoding.
      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         put(tbl[i], 1'b1);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_early_valid", i), {31'd0, bus.out_valid}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
         chk($sformatf("v%0d_instr", i), bus.out_instr, tbl[i].exp_instr);
         chk($sformatf("v%0d_err", i),   {31'd0, bus.out_err}, {31'd0, tbl[i].exp_err});
      end
      @(posedge clk);
      @(negedge clk);
      chk("tbl_count", {16'd0, enc_count}, NV);
      chk("tbl_drained", {31'd0, bus.out_valid}, 32'd0);

      // Reset with two words in flight.
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      put(tbl[0], 1'b1);
      @(posedge clk); #1;
      put(tbl[1], 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("inflight_valid", {31'd0, bus.out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst_enc_count", {16'd0, enc_count}, 32'd0);
      chk("midrst_out_instr", bus.out_instr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("no_stale_%0d", c), {31'd0, bus.out_valid}, 32'd0);
      end

      // Back-to-back with out_ready held high.
      seq[0] = 1; seq[1] = 3; seq[2] = 4; seq[3] = 5;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (c < 4) put(tbl[seq[c]], 1'b1);
         else       bus.in_valid = 1'b0;
         @(negedge clk);
         if (c < 4) chk($sformatf("b2b_in_ready_%0d", c), {31'd0, bus.in_ready}, 32'd1);
         chk($sformatf("b2b_valid_%0d", c), {31'd0, bus.out_valid},
             ((c >= 2) && (c <= 5)) ? 32'd1 : 32'd0);
         if ((c >= 2) && (c <= 5) && bus.out_valid)
            chk($sformatf("b2b_instr_%0d", c), bus.out_instr, tbl[seq[c-2]].exp_instr);
      end
      chk("b2b_count", {16'd0, enc_count}, 32'd4);

      // Backpressure: three bundles offered while the consumer stalls.
      bp[0] = tbl[0]; bp[1] = tbl[1]; bp[2] = tbl[7];
      idx  = 0;
      oidx = 0;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         bus.out_ready = (c >= 6);
         if (idx < 3) put(bp[idx], 1'b1);
         else         bus.in_valid = 1'b0;
         @(negedge clk);
         if ((c >= 2) && (c < 6)) begin
            chk($sformatf("bp_in_ready_%0d", c), {31'd0, bus.in_ready}, 32'd0);
            chk($sformatf("bp_hold_valid_%0d", c), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("bp_hold_instr_%0d", c), bus.out_instr, bp[0].exp_instr);
            chk($sformatf("bp_hold_err_%0d", c), {31'd0, bus.out_err}, 32'd0);
         end
         if (c == 5) chk("bp_accepted", idx, 32'd2);
         if (bus.out_valid && bus.out_ready) begin
            if (oidx < 3) chk($sformatf("bp_out_%0d", oidx), bus.out_instr, bp[oidx].exp_instr);
            oidx++;
         end
         if (bus.in_valid && bus.in_ready) idx++;
      end
      chk("bp_out_total", oidx, 32'd3);
      chk("bp_count", {16'd0, enc_count}, 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
